// File: rtl/hs32_sram_ctl.sv
// 32-bit word requests executed as two 16-bit async-SRAM accesses (IDLE/SETUP/STROBE/HOLD).
// Optional HS32_SRAM_RDY_EN adds sram_rdy to stretch STROBE until the device is ready.
module hs32_sram_ctl #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned WAIT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              rw,
  input  logic [31:0]       dtw,
  input  logic              valid,
  output logic [31:0]       dtr,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
`ifdef HS32_SRAM_RDY_EN
  output logic              sram_we_n,
  input  logic              sram_rdy
`else
  output logic              sram_we_n
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  state_t              state_q;
  logic                half_q;
  logic [3:0]          cnt_q;
  logic                rw_q;
  logic [ADDR_W-2:0]   addr_q;
  logic [31:0]         dtw_q;
  logic [31:0]         dtr_q;
  logic                done_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [15:0]         dq_o_q;
  logic                dq_oe_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic                rdy_d;

`ifdef HS32_SRAM_RDY_EN
  assign rdy_d = sram_rdy;
`else
  assign rdy_d = 1'b1;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_W+1], addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      half_q      <= 1'b0;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      dtw_q       <= 32'd0;
      dtr_q       <= 32'd0;
      done_q      <= 1'b0;
      sram_addr_q <= '0;
      dq_o_q      <= 16'd0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            rw_q        <= rw;
            addr_q      <= addr[ADDR_W:2];
            dtw_q       <= dtw;
            half_q      <= 1'b0;
            state_q     <= ST_SETUP;
            ce_n_q      <= 1'b0;
            sram_addr_q <= {addr[ADDR_W:2], 1'b0};
            if (rw) begin
              dq_oe_q <= 1'b1;
              dq_o_q  <= dtw[15:0];
            end
          end
        end
        ST_SETUP: begin
          state_q <= ST_STROBE;
          cnt_q   <= 4'(WAIT);
          if (rw_q) we_n_q <= 1'b0;
          else      oe_n_q <= 1'b0;
        end
        ST_STROBE: begin
          // Counter expiry plus device readiness ends the strobe; reads sample the pads here.
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (rdy_d) begin
            state_q <= ST_HOLD;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            done_q  <= half_q;
            if (!rw_q) begin
              if (half_q) dtr_q[31:16] <= sram_dq_i;
              else        dtr_q[15:0]  <= sram_dq_i;
            end
          end
        end
        ST_HOLD: begin
          if (!half_q) begin
            half_q      <= 1'b1;
            state_q     <= ST_SETUP;
            sram_addr_q <= {addr_q, 1'b1};
            if (rw_q) dq_o_q <= dtw_q[31:16];
          end else begin
            state_q <= ST_IDLE;
            ce_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dtr        = dtr_q;
  assign done       = done_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_hs32_sram_ctl.sv
// Scoreboard bench for hs32_sram_ctl: word-level reference memory vs. a half-word SRAM pad model.
`timescale 1ns/1ps
module tb_hs32_sram_ctl;
  localparam int ADDR_W = 17;
  localparam int WAIT   = 1;
  localparam int LAT    = 2 * (WAIT + 3);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       addr = 32'd0;
  logic              rw = 1'b0;
  logic [31:0]       dtw = 32'd0;
  logic              valid = 1'b0;
  logic [31:0]       dtr;
  logic              done;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic [15:0]       sram_dq_i;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic              sram_rdy = 1'b1;

  hs32_sram_ctl #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rw(rw), .dtw(dtw), .valid(valid),
    .dtr(dtr), .done(done), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
`ifdef HS32_SRAM_RDY_EN
    .sram_we_n(sram_we_n), .sram_rdy(sram_rdy)
`else
    .sram_we_n(sram_we_n)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] refw [0:127];
  logic [31:0] last_dtr = 32'd0;
  assign sram_dq_i = (!sram_oe_n && !sram_ce_n && sram_rdy) ? mem[sram_addr] : 16'h0BAD;

  typedef struct { logic [31:0] dtr; int cyc; } exp_t;
  exp_t exp_q[$];
  logic [ADDR_W-1:0] bus_addr_q[$];

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  ce_run = 0;
  int  st_run = 0;
  bit  chk_len = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops on done, SRAM pad model, bus protocol rules.
  always @(negedge clk) begin
    if (reset) begin
      ce_run = 0;
      st_run = 0;
    end else begin
      chk("oe_we_exclusive", {63'd0, !(!sram_oe_n && !sram_we_n)}, 64'd1);
      chk("oe_vs_dq_oe", {63'd0, !(!sram_oe_n && sram_dq_oe)}, 64'd1);
      if (sram_ce_n) chk("idle_bus", {61'd0, sram_oe_n, sram_we_n, sram_dq_oe}, 64'b110);
      if (!sram_we_n && !sram_ce_n) begin
        chk("write_dq_oe", {63'd0, sram_dq_oe}, 64'd1);
        mem[sram_addr] = sram_dq_o;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no transaction pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dtr", {32'd0, dtr}, {32'd0, e.dtr});
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (!sram_oe_n || !sram_we_n) begin
        if (st_run == 0) bus_addr_q.push_back(sram_addr);
        st_run++;
      end else if (st_run != 0) begin
        if (chk_len) chk("strobe_len", 64'(st_run), 64'(WAIT + 1));
        st_run = 0;
      end
      if (!sram_ce_n) ce_run++;
      else if (ce_run != 0) begin
        if (chk_len) chk("ce_len", 64'(ce_run), 64'(LAT));
        ce_run = 0;
      end
    end
  end

  task automatic drive_req(input bit w, input int word, input logic [31:0] d, input bit rnd_bits);
    logic [31:0] a;
    a = rnd_bits ? $urandom : 32'd0;
    a[ADDR_W:2] = 16'(word);
    addr = a;
    rw = w;
    dtw = d;
    valid = 1'b1;
    if (w) refw[word] = d;
    else   last_dtr = refw[word];
  endtask

  task automatic issue(input bit w, input int word, input logic [31:0] d, input bit rnd_bits);
    @(posedge clk); #1;
    drive_req(w, word, d, rnd_bits);
    exp_q.push_back('{last_dtr, cyc + LAT});
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int start, lowcnt;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8] = 16'hBEEF;
    mem[9] = 16'hDEAD;
    for (int i = 0; i < 128; i++) refw[i] = {mem[2*i+1], mem[2*i]};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dtr", {32'd0, dtr}, 64'd0);
    chk("reset_bus", {59'd0, done, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 64'b00111);
    chk("reset_addr_dq", {31'd0, sram_addr, sram_dq_o}, 64'd0);
    reset = 1'b0;

    // Read of 0x10: halves at 0x8/0x9.
    bus_addr_q.delete();
    issue(1'b0, 4, 32'd0, 1'b0);
    wait_idle();
    chk("rd_halves", 64'(bus_addr_q.size()), 64'd2);
    if (bus_addr_q.size() == 2) begin
      chk("rd_addr0", 64'(bus_addr_q[0]), 64'h8);
      chk("rd_addr1", 64'(bus_addr_q[1]), 64'h9);
    end

    // Write 0x12345678 to 0x4: halves at 0x2/0x3, dtr untouched.
    bus_addr_q.delete();
    issue(1'b1, 1, 32'h1234_5678, 1'b0);
    wait_idle();
    chk("wr_lo", {48'd0, mem[2]}, 64'h5678);
    chk("wr_hi", {48'd0, mem[3]}, 64'h1234);
    if (bus_addr_q.size() == 2) begin
      chk("wr_addr0", 64'(bus_addr_q[0]), 64'h2);
      chk("wr_addr1", 64'(bus_addr_q[1]), 64'h3);
    end else chk("wr_halves", 64'(bus_addr_q.size()), 64'd2);

    // Back-to-back: read then write with valid held across done.
    @(posedge clk); #1;
    drive_req(1'b0, 5, 32'd0, 1'b1);
    start = cyc;
    exp_q.push_back('{last_dtr, start + LAT});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk); #1;
    drive_req(1'b1, 6, 32'hCAFE_F00D, 1'b1);
    exp_q.push_back('{last_dtr, start + LAT + 1 + LAT});
    @(posedge clk); #1;
    valid = 1'b0;
    wait_idle();

    // Reset during the first-half strobe of a read.
    issue(1'b0, 4, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_oe_n) break;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_bus", {59'd0, done, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 64'b00111);
    chk("rst_mid_dtr", {32'd0, dtr}, 64'd0);
    reset = 1'b0;
    last_dtr = 32'd0;
    issue(1'b0, 4, 32'd0, 1'b1);
    wait_idle();

    // valid pulse during the strobe of a write is ignored.
    issue(1'b1, 7, 32'hA5A5_5A5A, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) break;
    end
    @(posedge clk); #1;
    addr = 32'h40; rw = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    wait_idle();
    lowcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!sram_ce_n) lowcnt++;
    end
    chk("no_extra_bus", 64'(lowcnt), 64'd0);

`ifdef HS32_SRAM_RDY_EN
    // sram_rdy low for 3 extra cycles on the first-half read strobe.
    chk_len = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b0, 4, 32'd0, 1'b0);
    start = cyc;
    exp_q.push_back('{last_dtr, start + LAT + 3});
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sram_rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    sram_rdy = 1'b1;
    wait_idle();
    chk_len = 1'b1;
`endif

    // Randomised mix over a small window so reads hit earlier writes.
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 1'b1);
      wait_idle();
    end
    for (int wd = 0; wd < 16; wd += 3) begin
      issue(1'b0, wd, 32'd0, 1'b1);
      wait_idle();
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hs32_sram_ctl.md
Name: hs32_sram_ctl

Overview:
- External-memory controller sitting directly downstream of the internal memory arbiter.
- Takes one 32-bit word request per transaction: address, direction, write data and a start strobe.
- Executes it as two sequential 16-bit accesses on an asynchronous SRAM bus with programmable wait states.
- Returns read data plus a one-cycle done pulse to the arbiter.

Parameters:
- ADDR_W, 17, width of the SRAM half-word address bus.
- WAIT, 1, extra strobe cycles per half-word access (0..15); strobe phase lasts WAIT+1 cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  32  word byte-address; bits [1:0] ignored; bits above ADDR_W ignored
- rw  input  1  1 = write, 0 = read
- dtw  input  32  write data
- valid  input  1  request strobe (arbiter's wvalid); asserted for reads and writes
- dtr  output  32  read data
- done  output  1  transaction complete; dtr valid for reads
- sram_addr  output  ADDR_W  half-word address
- sram_dq_o  output  16  write data to pads
- sram_dq_i  input  16  read data from pads
- sram_dq_oe  output  1  pad output enable
- sram_ce_n  output  1  chip enable, active low
- sram_oe_n  output  1  output enable, active low
- sram_we_n  output  1  write enable, active low

Behaviour:
- Reset values: dtr=0, done=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, state IDLE, half=0.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - valid sampled only here.
  - When valid=1, latch addr, rw and dtw; half<=0; go to SETUP.
  - valid in any other state is ignored.
- SETUP, 1 cycle:
  - sram_ce_n=0; sram_addr={addr[ADDR_W:2], half}.
  - For writes: sram_dq_oe=1, sram_dq_o = half ? dtw[31:16] : dtw[15:0].
- STROBE, WAIT+1 cycles, counted by a 4-bit down-counter:
  - ce_n=0; reads drive oe_n=0, writes drive we_n=0.
  - Reads capture sram_dq_i at the end of the last STROBE cycle into dtr[15:0] (half=0) or dtr[31:16] (half=1).
- HOLD, 1 cycle:
  - ce_n=0; oe_n=we_n=1; address and write data remain driven (dq_oe stays 1 for writes).
  - If half=0: half<=1, go to SETUP.
  - If half=1: go to IDLE; done=1 during this cycle.
- done:
  - Decoded from registered state (HOLD && half); no combinational path from any input.
  - High exactly one cycle per transaction.
- Latency: done is high in cycle 2*(WAIT+3) after the accept cycle (cycle 0). WAIT=1 gives cycle 8.
- Back-to-back: the arbiter drops valid after seeing done. If valid is still high in the following IDLE cycle, a new transaction starts immediately, giving a minimum 1-cycle gap.
- Bus idle:
  - In IDLE, ce_n=oe_n=we_n=1 and sram_dq_oe=0.
  - sram_addr and sram_dq_o hold their last values.
- dtr is only modified by reads; it holds its value across writes and idle periods.
- Reset mid-transaction: at the reset edge all strobes deassert, dq_oe=0, done=0, state IDLE. Partial read data is discarded and dtr is cleared.
- No cycle ever has oe_n=0 and we_n=0 together, or oe_n=0 with dq_oe=1.

Optional Feature:
- Macro: HS32_SRAM_RDY_EN.
- Defined:
  - Adds input port sram_rdy (1 bit, active high).
  - STROBE stays in place past its WAIT+1 cycles for as long as sram_rdy=0.
  - Read capture happens on the first cycle where the counter has expired and sram_rdy=1.
  - No timeout.
- Undefined:
  - No sram_rdy port.
  - STROBE is always exactly WAIT+1 cycles.

Test Plan:
- Read, WAIT=1, addr=0x0000_0010; SRAM model returns 0xBEEF @0x8 and 0xDEAD @0x9 -> sram_addr 0x8 then 0x9; oe_n low 2 cycles per half; done high in cycle 8 only with dtr=0xDEADBEEF.
- Write, WAIT=1, addr=0x0000_0004, dtw=0x1234_5678 -> we_n low 2 cycles with sram_addr=0x2, dq_o=0x5678, then sram_addr=0x3, dq_o=0x1234; dq_oe high throughout SETUP..HOLD of both halves; dtr unchanged; done at cycle 8.
- WAIT=0 read followed by write, valid held high across done -> second transaction accepted in the IDLE cycle right after done; first done at cycle 6, second done 7 cycles later.
- Reset asserted during the first-half STROBE of a read -> next cycle all strobes high, dq_oe=0, done=0, dtr=0; a new read after reset completes normally.
- valid pulsed high during STROBE of an in-flight write -> ignored; exactly one done, no extra bus cycle.
- HS32_SRAM_RDY_EN defined, WAIT=1, sram_rdy low for 3 extra cycles on the first half of a read -> that STROBE lasts 5 cycles; done at cycle 11; data captured on the rdy=1 cycle.
